// File: rtl/clock_io_frontend.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// clock_io_frontend
//
// Board-side front end of the 24-hour wall clock.
//   * Stretches and synchronises the raw reset button into Reset_Out.
//   * Debounces the minute/hour set buttons into single-cycle Set_x pulses.
//   * Scans four BCD digits (HH:MM) onto a 4-digit common-anode display.
// All outputs are registered in the Clk_100M domain.
//
// Parameters:
//   DEBOUNCE_CYCLES    - consecutive stable cycles needed to accept a level
//   RESET_DELAY_CYCLES - cycles the reset button must stay released
//   REFRESH_CYCLES     - cycles each digit is shown per scan step
//
// Ports:
//   Clk_100M        in   system clock, rising edge
//   Reset           in   asynchronous active-high reset
//   button          in   raw reset button, active-high, asynchronous
//   Button_Minutes  in   raw minute-set button, active-high
//   Button_Hours    in   raw hour-set button, active-high
//   hoursTens/hoursUnits/minutesTens/minutesUnits  in [3:0]  BCD digits
//   Reset_Out       out  stretched reset for the core, active-high
//   Set_Minutes     out  one-cycle pulse per accepted minute press
//   Set_Hours       out  one-cycle pulse per accepted hour press
//   SegmentDrivers  out [3:0] digit anodes, active-low
//                        (0=minutesUnits, 1=minutesTens, 2=hoursUnits, 3=hoursTens)
//   SevenSegment    out [7:0] cathodes, active-low, {DP,g,f,e,d,c,b,a}
//
// Optional build macro:
//   DP_COLON_EN - when defined, the decimal point is lit on the hoursUnits
//                 digit to form an HH.MM separator; otherwise DP stays dark.
// -----------------------------------------------------------------------------
module clock_io_frontend #(
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int RESET_DELAY_CYCLES = 5_000_000,
  parameter int REFRESH_CYCLES     = 100_000
) (
  input  logic       Clk_100M,
  input  logic       Reset,
  input  logic       button,
  input  logic       Button_Minutes,
  input  logic       Button_Hours,
  input  logic [3:0] hoursTens,
  input  logic [3:0] hoursUnits,
  input  logic [3:0] minutesTens,
  input  logic [3:0] minutesUnits,
  output logic       Reset_Out,
  output logic       Set_Minutes,
  output logic       Set_Hours,
  output logic [3:0] SegmentDrivers,
  output logic [7:0] SevenSegment
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RD_W = $clog2(RESET_DELAY_CYCLES + 1);
  localparam int RF_W = $clog2(REFRESH_CYCLES + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RD_W-1:0] RD_MAX  = RD_W'(RESET_DELAY_CYCLES);
  localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers: bit 0 reset button, bit 1 minutes, bit 2 hours.
  // ---------------------------------------------------------------------------
  logic [2:0] w_btn_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;

  assign w_btn_raw = {Button_Hours, Button_Minutes, button};

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Reset stretch. The output register lags the counter by one cycle, so the
  // output falls on the cycle after the counter reaches RESET_DELAY_CYCLES.
  // ---------------------------------------------------------------------------
  logic [RD_W-1:0] r_rst_cnt;
  logic            r_reset_out;

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      r_rst_cnt   <= '0;
      r_reset_out <= 1'b1;
    end else if (r_sync2[0]) begin
      r_rst_cnt   <= '0;
      r_reset_out <= 1'b1;
    end else begin
      r_reset_out <= (r_rst_cnt < RD_MAX);
      if (r_rst_cnt != RD_MAX) begin
        r_rst_cnt <= r_rst_cnt + RD_W'(1);
      end
    end
  end

  assign Reset_Out = r_reset_out;

  // ---------------------------------------------------------------------------
  // Debouncers: index 0 = minutes, index 1 = hours.
  // The rising-edge pulse is taken one cycle after the stable state flips.
  // ---------------------------------------------------------------------------
  logic [1:0] w_set;

  for (genvar gi = 0; gi < 2; gi++) begin : g_debounce
    logic [DB_W-1:0] r_db_cnt;
    logic            r_stable;
    logic            r_stable_d;
    logic            r_set;

    always_ff @(posedge Clk_100M or posedge Reset) begin
      if (Reset) begin
        r_db_cnt   <= '0;
        r_stable   <= 1'b0;
        r_stable_d <= 1'b0;
        r_set      <= 1'b0;
      end else begin
        r_stable_d <= r_stable;
        r_set      <= r_stable & ~r_stable_d;
        if (r_sync2[gi+1] == r_stable) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
          r_stable <= r_sync2[gi+1];
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end
    end

    assign w_set[gi] = r_set;
  end

  assign Set_Minutes = w_set[0];
  assign Set_Hours   = w_set[1];

  // ---------------------------------------------------------------------------
  // Display scan
  // ---------------------------------------------------------------------------
  logic [RF_W-1:0] r_refresh;
  logic [1:0]      r_index;

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      r_refresh <= '0;
      r_index   <= 2'd0;
    end else if (r_refresh == RF_LAST) begin
      r_refresh <= '0;
      r_index   <= r_index + 2'd1;
    end else begin
      r_refresh <= r_refresh + RF_W'(1);
    end
  end

  logic [3:0] w_digit;
  logic [6:0] w_seg;
  logic       w_dp;
  logic [3:0] w_anode;

  always_comb begin
    w_digit = minutesUnits;
    case (r_index)
      2'd0:    w_digit = minutesUnits;
      2'd1:    w_digit = minutesTens;
      2'd2:    w_digit = hoursUnits;
      default: w_digit = hoursTens;
    endcase
  end

  // Active-low {g..a}; codes 10-15 are blanked.
  always_comb begin
    w_seg = 7'h7F;
    case (w_digit)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h7F;
    endcase
  end

`ifdef DP_COLON_EN
  // Lit decimal point after hoursUnits acts as the HH.MM separator.
  assign w_dp = (r_index != 2'd2);
`else
  assign w_dp = 1'b1;
`endif

  for (genvar gi = 0; gi < 4; gi++) begin : g_anode
    assign w_anode[gi] = (r_index != 2'(gi));
  end

  logic [3:0] r_anode;
  logic [7:0] r_seg;

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      r_anode <= 4'b1111;
      r_seg   <= 8'hFF;
    end else begin
      r_anode <= w_anode;
      r_seg   <= {w_dp, w_seg};
    end
  end

  assign SegmentDrivers = r_anode;
  assign SevenSegment   = r_seg;

endmodule

// File: tb/tb_clock_io_frontend.sv
`timescale 1ns/1ps
// Testbench for clock_io_frontend with small parameters. Each task drives one
// scenario and compares against a behavioural model written from the
// timing rules (edge numbers counted from reset release).
module tb_clock_io_frontend;

  localparam int D   = 4;   // DEBOUNCE_CYCLES
  localparam int N   = 8;   // RESET_DELAY_CYCLES
  localparam int R   = 3;   // REFRESH_CYCLES
  localparam int LEN = 120;

`ifdef DP_COLON_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       button = 1'b0;
  logic       bm     = 1'b0;
  logic       bh     = 1'b0;
  logic [3:0] ht = 4'd0, hu = 4'd0, mt = 4'd0, mu = 4'd0;
  logic       reset_out, set_m, set_h;
  logic [3:0] anodes;
  logic [7:0] segs;

  int errors = 0;
  int checks = 0;

  bit raw   [0:1][0:LEN-1];
  bit exp_p [0:1][0:LEN+7];
  bit raw_b [0:LEN-1];

  always #5 clk = ~clk;

  clock_io_frontend #(
    .DEBOUNCE_CYCLES   (D),
    .RESET_DELAY_CYCLES(N),
    .REFRESH_CYCLES    (R)
  ) dut (
    .Clk_100M      (clk),
    .Reset         (rst),
    .button        (button),
    .Button_Minutes(bm),
    .Button_Hours  (bh),
    .hoursTens     (ht),
    .hoursUnits    (hu),
    .minutesTens   (mt),
    .minutesUnits  (mu),
    .Reset_Out     (reset_out),
    .Set_Minutes   (set_m),
    .Set_Hours     (set_h),
    .SegmentDrivers(anodes),
    .SevenSegment  (segs)
  );

  function automatic logic [7:0] seg_ref(input logic [3:0] d, input int idx);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    if (DP_EN && idx == 2) s[7] = 1'b0;
    return s;
  endfunction

  // Asserts Reset between clock edges, then releases it on a falling edge.
  task automatic do_reset(input int hold);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (hold) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bm = 1'b1; bh = 1'b1; button = 1'b0; mu = 4'd8;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (reset_out !== 1'b1) begin
        errors++; $display("FAIL reset_hold_reset_out: got %b want 1", reset_out);
      end
      checks++;
      if ({set_m, set_h} !== 2'b00) begin
        errors++; $display("FAIL reset_hold_pulses: got %b%b want 00", set_m, set_h);
      end
      checks++;
      if (anodes !== 4'hF || segs !== 8'hFF) begin
        errors++; $display("FAIL reset_hold_display: got %b/%h want 1111/ff", anodes, segs);
      end
    end
    bm = 1'b0; bh = 1'b0; rst = 1'b0;
    for (int k = 1; k <= N + 4; k++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (reset_out !== (k <= N)) begin
        errors++; $display("FAIL power_on_stretch edge %0d: got %b want %b", k, reset_out, (k <= N));
      end
    end
    $display("power-on stretch: %0d edges observed", N + 4);
    // Asynchronous assertion between edges, mid-scan.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (reset_out !== 1'b1 || anodes !== 4'hF || segs !== 8'hFF) begin
      errors++;
      $display("FAIL async_reset: got ro=%b an=%b seg=%h want 1/1111/ff", reset_out, anodes, segs);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_display(input string name, input int cycles, input bit rnd);
    int         idx;
    logic [3:0] ea, d;
    logic [7:0] es;
    do_reset(2);
    for (int k = 1; k <= cycles; k++) begin
      if (rnd) begin
        mu = 4'($urandom_range(0, 15)); mt = 4'($urandom_range(0, 15));
        hu = 4'($urandom_range(0, 15)); ht = 4'($urandom_range(0, 15));
      end
      @(posedge clk); @(negedge clk);
      idx = ((k - 1) / R) % 4;
      ea = 4'hF;
      ea[idx] = 1'b0;
      case (idx)
        0:       d = mu;
        1:       d = mt;
        2:       d = hu;
        default: d = ht;
      endcase
      es = seg_ref(d, idx);
      checks++;
      if (anodes !== ea) begin
        errors++; $display("FAIL %s anodes edge %0d: got %b want %b", name, k, anodes, ea);
      end
      checks++;
      if (segs !== es) begin
        errors++; $display("FAIL %s segments edge %0d: got %h want %h", name, k, segs, es);
      end
    end
    $display("display %s: %0d cycles", name, cycles);
  endtask

  // mode 0: directed pattern; otherwise random bursts.
  task automatic test_debounce(input string name, input int mode);
    int cnt_m, cnt_h, first_h;
    for (int b = 0; b < 2; b++) begin
      for (int j = 0; j < LEN; j++) raw[b][j] = 1'b0;
      for (int e = 0; e < LEN + 8; e++) exp_p[b][e] = 1'b0;
    end
    if (mode == 0) begin
      for (int j = 0; j < 3; j++)  raw[0][j] = 1'b1;
      for (int j = 6; j < 16; j++) raw[0][j] = 1'b1;
      for (int j = 0; j < 50; j++) raw[1][j] = 1'b1;
    end else begin
      for (int b = 0; b < 2; b++) begin
        int j;
        bit lvl;
        j = 0;
        lvl = 1'b1;
        while (j < LEN - 20) begin
          int len;
          len = $urandom_range(1, 2 * D);
          for (int i = 0; i < len; i++) begin
            raw[b][j] = lvl;
            j++;
          end
          lvl = ~lvl;
        end
      end
    end
    // Model: a press is accepted once D consecutive samples differ from the
    // accepted level; a 0->1 acceptance pulses 4 edges after that sample.
    for (int b = 0; b < 2; b++) begin
      bit stable;
      int run;
      stable = 1'b0;
      run = 0;
      for (int j = 0; j < LEN; j++) begin
        if (raw[b][j] != stable) begin
          run++;
          if (run == D) begin
            stable = raw[b][j];
            run = 0;
            if (stable) exp_p[b][j + 4] = 1'b1;
          end
        end else begin
          run = 0;
        end
      end
    end
    cnt_m = 0; cnt_h = 0; first_h = -1;
    do_reset(2);
    for (int e = 1; e < LEN + 8; e++) begin
      bm = (e - 1 < LEN) ? raw[0][e - 1] : 1'b0;
      bh = (e - 1 < LEN) ? raw[1][e - 1] : 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (set_m !== exp_p[0][e]) begin
        errors++; $display("FAIL %s set_minutes edge %0d: got %b want %b", name, e, set_m, exp_p[0][e]);
      end
      checks++;
      if (set_h !== exp_p[1][e]) begin
        errors++; $display("FAIL %s set_hours edge %0d: got %b want %b", name, e, set_h, exp_p[1][e]);
      end
      if (set_m === 1'b1) cnt_m++;
      if (set_h === 1'b1) begin
        cnt_h++;
        if (first_h < 0) first_h = e;
      end
    end
    bm = 1'b0; bh = 1'b0;
    if (mode == 0) begin
      checks++;
      if (cnt_m != 1) begin
        errors++; $display("FAIL %s minute_pulse_count: got %0d want 1", name, cnt_m);
      end
      checks++;
      if (cnt_h != 1) begin
        errors++; $display("FAIL %s hour_pulse_count: got %0d want 1", name, cnt_h);
      end
      checks++;
      if (first_h != 7) begin
        errors++; $display("FAIL %s hour_pulse_latency: got edge %0d want 7", name, first_h);
      end
    end
    $display("debounce %s: minute pulses %0d, hour pulses %0d", name, cnt_m, cnt_h);
  endtask

  task automatic test_reset_button();
    int  j;
    bit  lvl;
    bit  expv;
    for (int i = 0; i < LEN; i++) raw_b[i] = 1'b0;
    for (int i = 20; i < 26; i++) raw_b[i] = 1'b1;
    j = 26 + N + 6;
    lvl = 1'b1;
    while (j < LEN - 10) begin
      int len;
      len = lvl ? $urandom_range(1, 3) : $urandom_range(1, 2 * N + 4);
      for (int i = 0; i < len && j < LEN; i++) begin
        raw_b[j] = lvl;
        j++;
      end
      lvl = ~lvl;
    end
    do_reset(2);
    for (int e = 1; e < LEN + N + 6; e++) begin
      button = (e - 1 < LEN) ? raw_b[e - 1] : 1'b0;
      @(posedge clk); @(negedge clk);
      // Reset_Out is high for the power-on stretch and for edges
      // [j+3, j+3+N] after any sample j where the button was pressed.
      expv = (e <= N);
      for (int i = 0; i < LEN; i++) begin
        if (raw_b[i] && e >= i + 3 && e <= i + 3 + N) expv = 1'b1;
      end
      checks++;
      if (reset_out !== expv) begin
        errors++; $display("FAIL reset_button edge %0d: got %b want %b", e, reset_out, expv);
      end
    end
    button = 1'b0;
    $display("reset button: %0d edges observed", LEN + N + 5);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    ht = 4'd1; hu = 4'd2; mt = 4'd3; mu = 4'd4;
    test_display("digits_1234", 5 * R, 1'b0);
    mu = 4'hC;
    test_display("blank", R, 1'b0);
    test_display("random", 120, 1'b1);
    test_debounce("directed", 0);
    test_debounce("random_a", 1);
    test_debounce("random_b", 2);
    test_debounce("random_c", 3);
    test_reset_button();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
